// File: rtl/sevenseg_scan_driver.sv
// Purpose: time-multiplexed DIGITS-wide hex display driver for a common-anode seven-segment module.
// Latency: an/seg/dp are registered one cycle behind the slot/digit counters; new data appears at the next frame boundary.
// Backpressure: none. load is accepted every cycle, and the last load before a frame boundary wins.
module sevenseg_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BRIGHT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // Wide enough that neither side of the brightness compare can overflow.
    localparam int PW = CW + BRIGHT_W + 1;

    typedef struct packed {
        logic [4*DIGITS-1:0] value;
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   en;
        logic                blz;
        logic [BRIGHT_W-1:0] bright;
    } buf_t;

    logic [CW-1:0]     r_slot;
    logic [IW-1:0]     r_idx;
    buf_t              r_pend;
    buf_t              r_act;
    logic [DIGITS-1:0] r_an;
    logic [6:0]        r_seg;
    logic              r_dp;
    logic              r_frame_done;

    buf_t              w_in;
    logic              w_slot_last;
    logic              w_idx_last;
    logic              w_fb;
    logic [DIGITS-1:0] w_lz_blank;
    logic [3:0]        w_nib;
    logic              w_bright_ok;
    logic              w_lit;

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Gather the capture inputs into one buffer image.
    always_comb begin
        w_in.value  = value;
        w_in.dp     = dp_in;
        w_in.en     = digit_en;
        w_in.blz    = blank_lz;
        w_in.bright = brightness;
    end

    assign w_slot_last = (r_slot == CW'(REFRESH_DIV - 1));
    assign w_idx_last  = (r_idx == IW'(DIGITS - 1));
    assign w_fb        = w_slot_last && w_idx_last;

    // Slot counter and digit index. A reset restarts the frame from digit 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot <= '0;
            r_idx  <= '0;
        end else if (w_slot_last) begin
            r_slot <= '0;
            r_idx  <= w_idx_last ? '0 : r_idx + IW'(1);
        end else begin
            r_slot <= r_slot + CW'(1);
        end
    end

    // Double buffer. The display reads only r_act, which changes only at a frame boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_act  <= '0;
        end else begin
            if (load) begin
                r_pend <= w_in;
            end
            if (w_fb) begin
                r_act <= load ? w_in : r_pend;
            end
        end
    end

    // Leading-zero mask. Walk down from the top digit while the nibbles stay zero. Digit 0 is never masked.
    always_comb begin
        logic v_zero_run;
        v_zero_run = 1'b1;
        w_lz_blank = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            v_zero_run    = v_zero_run & (r_act.value[4*i +: 4] == 4'h0);
            w_lz_blank[i] = r_act.blz & v_zero_run;
        end
    end

    assign w_nib = r_act.value[4*r_idx +: 4];

    // Duty-cycle window. Slot cycle 1 is always on, so the dimmest setting still shows one cycle.
    assign w_bright_ok = (r_slot == CW'(1)) ||
                         ((PW'(r_slot) << BRIGHT_W) <
                          ((PW'(r_act.bright) + PW'(1)) * PW'(REFRESH_DIV)));

    // Slot cycle 0 is dead time, so the previous anode is fully off before the next one drives.
    assign w_lit = r_act.en[r_idx] && !w_lz_blank[r_idx] && (r_slot != '0) && w_bright_ok;

    // Register all pins together, so anode, cathodes and dp switch on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an         <= '1;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_fb;
            if (w_lit) begin
                r_an  <= ~(DIGITS'(1) << r_idx);
                r_seg <= ~hex7(w_nib);
                r_dp  <= ~r_act.dp[r_idx];
            end else begin
                r_an  <= '1;
                r_seg <= 7'h7F;
                r_dp  <= 1'b1;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver (DIGITS=4, REFRESH_DIV=8, BRIGHT_W=4).
// Each step queues the expected pins for the coming edge, then pops and compares them after the edge.
// Spot checks of the decoded frame table cover the listed display scenarios.
module tb_sevenseg_scan_driver;

    localparam int D = 4;
    localparam int R = 8;
    localparam int B = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        blank_lz;
    logic [3:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    always #5 clk = ~clk;

    sevenseg_scan_driver #(.DIGITS(D), .REFRESH_DIV(R), .BRIGHT_W(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dpv;
        logic [3:0]  en;
        logic        blz;
        logic [3:0]  br;
    } buf_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int    n_assert = 0;
    int    n_fail   = 0;
    int    fd_count = 0;
    int    m_slot   = 0;
    int    m_idx    = 0;
    buf_t  m_pend   = '0;
    buf_t  m_act    = '0;
    exp_t  q [$];
    string phase    = "init";

    logic [3:0] obs_an  [4][8];
    logic [6:0] obs_seg [4][8];
    logic       obs_dp  [4][8];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, expv);
        end
    endtask

    // Expected pins for the edge after the current model state.
    function automatic exp_t model_out();
        exp_t e;
        int   hi;
        int   lim;
        bit   lit;
        logic [3:0] nib;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.fd  = (m_slot == R - 1) && (m_idx == D - 1);
        hi = -1;
        for (int i = 0; i < D; i++) begin
            if (m_act.val[i*4 +: 4] != 4'h0) hi = i;
        end
        // The slot is on while s < (br+1)*R/2^B; take the ceiling of that limit.
        lim = ((int'(m_act.br) + 1) * R + (1 << B) - 1) / (1 << B);
        lit = m_act.en[m_idx] && !(m_act.blz && m_idx >= 1 && m_idx > hi) &&
              (m_slot != 0) && (m_slot == 1 || m_slot < lim);
        if (lit) begin
            nib   = m_act.val[m_idx*4 +: 4];
            e.an  = ~(4'b0001 << m_idx);
            e.seg = ~dec_tab[nib];
            e.dp  = ~m_act.dpv[m_idx];
        end
        return e;
    endfunction

    task automatic step();
        exp_t e;
        exp_t x;
        buf_t inb;
        int   ps;
        int   pi;
        logic was_rst;
        inb     = '{value, dp_in, digit_en, blank_lz, brightness};
        ps      = m_slot;
        pi      = m_idx;
        was_rst = !rst_n;
        if (was_rst) e = '{4'hF, 7'h7F, 1'b1, 1'b0};
        else         e = model_out();
        q.push_back(e);
        if (was_rst) begin
            m_slot = 0;
            m_idx  = 0;
            m_pend = '0;
            m_act  = '0;
        end else begin
            if (m_slot == R - 1 && m_idx == D - 1) m_act = load ? inb : m_pend;
            if (load) m_pend = inb;
            if (m_slot == R - 1) begin
                m_slot = 0;
                m_idx  = (m_idx + 1) % D;
            end else begin
                m_slot++;
            end
        end
        @(posedge clk);
        #1;
        x = q.pop_front();
        check("an",  16'(an),         16'(x.an));
        check("seg", 16'(seg),        16'(x.seg));
        check("dp",  16'(dp),         16'(x.dp));
        check("fd",  16'(frame_done), 16'(x.fd));
        if (frame_done === 1'b1) fd_count++;
        if (!was_rst) begin
            obs_an[pi][ps]  = an;
            obs_seg[pi][ps] = seg;
            obs_dp[pi][ps]  = dp;
        end
    endtask

    task automatic run_until(input int s, input int d);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (m_slot == s && m_idx == d) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        check("wait_timeout", 16'(hit), 16'd1);
    endtask

    task automatic run_frame();
        for (int k = 0; k < D * R; k++) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dpi, input logic [3:0] en,
                           input logic blz, input logic [3:0] br);
        value      = v;
        dp_in      = dpi;
        digit_en   = en;
        blank_lz   = blz;
        brightness = br;
        load       = 1'b1;
        step();
        load       = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        value      = 16'h0;
        dp_in      = 4'h0;
        digit_en   = 4'h0;
        blank_lz   = 1'b0;
        brightness = 4'h0;

        // Reset, then idle for 3 frames.
        phase = "reset";
        repeat (5) step();
        check("rst_an",  16'(an),  16'hF);
        check("rst_seg", 16'(seg), 16'h7F);
        check("rst_dp",  16'(dp),  16'h1);
        rst_n    = 1'b1;
        phase    = "idle";
        fd_count = 0;
        repeat (3 * D * R) step();
        check("fd_count", 16'(fd_count), 16'd3);
        check("idle_an",  16'(obs_an[2][4]), 16'hF);

        // Basic scan.
        phase = "scan";
        do_load(16'h12A0, 4'b0010, 4'hF, 1'b0, 4'hF);
        run_until(0, 0);
        run_frame();
        check("d0_an",  16'(obs_an[0][2]),  16'hE);
        check("d0_seg", 16'(obs_seg[0][2]), 16'h40);
        check("d1_an",  16'(obs_an[1][2]),  16'hD);
        check("d1_seg", 16'(obs_seg[1][2]), 16'h08);
        check("d1_dp",  16'(obs_dp[1][2]),  16'h0);
        check("d2_an",  16'(obs_an[2][2]),  16'hB);
        check("d2_seg", 16'(obs_seg[2][2]), 16'h24);
        check("d3_an",  16'(obs_an[3][7]),  16'h7);
        check("d3_seg", 16'(obs_seg[3][7]), 16'h79);
        check("d3_dead", 16'(obs_an[3][0]), 16'hF);

        // Leading-zero blanking.
        phase = "lz";
        do_load(16'h0040, 4'h0, 4'hF, 1'b1, 4'hF);
        run_until(0, 0);
        run_frame();
        check("d3_dark", 16'(obs_an[3][3]),  16'hF);
        check("d2_dark", 16'(obs_an[2][3]),  16'hF);
        check("d1_seg",  16'(obs_seg[1][3]), 16'h19);
        check("d0_seg",  16'(obs_seg[0][3]), 16'h40);
        do_load(16'h0000, 4'hF, 4'hF, 1'b1, 4'hF);
        run_until(0, 0);
        run_frame();
        check("z_d0_an",  16'(obs_an[0][3]),  16'hE);
        check("z_d0_seg", 16'(obs_seg[0][3]), 16'h40);
        check("z_d1_an",  16'(obs_an[1][3]),  16'hF);
        check("z_d1_dp",  16'(obs_dp[1][3]),  16'h1);
        do_load(16'h1234, 4'h0, 4'b1110, 1'b1, 4'hF);
        run_until(0, 0);
        run_frame();
        check("en_d0_an",  16'(obs_an[0][3]),  16'hF);
        check("en_d1_seg", 16'(obs_seg[1][3]), 16'h30);

        // Brightness.
        phase = "bright";
        do_load(16'h12A0, 4'h0, 4'hF, 1'b0, 4'h7);
        run_until(0, 0);
        run_frame();
        check("b7_s3", 16'(obs_an[1][3]), 16'hD);
        check("b7_s4", 16'(obs_an[1][4]), 16'hF);
        do_load(16'h12A0, 4'h0, 4'hF, 1'b0, 4'h0);
        run_until(0, 0);
        run_frame();
        check("b0_s1", 16'(obs_an[2][1]), 16'hB);
        check("b0_s2", 16'(obs_an[2][2]), 16'hF);

        // Tear-free update.
        phase = "tear";
        repeat (5) step();
        do_load(16'h1111, 4'h0, 4'hF, 1'b0, 4'hF);
        repeat (3) step();
        do_load(16'h2222, 4'h0, 4'hF, 1'b0, 4'hF);
        run_until(0, 0);
        check("cur_d3", 16'(obs_seg[3][1]), 16'h79);
        check("cur_d2", 16'(obs_seg[2][1]), 16'h24);
        run_frame();
        check("new_d0", 16'(obs_seg[0][2]), 16'h24);
        check("new_d3", 16'(obs_seg[3][5]), 16'h24);
        run_until(R - 1, D - 1);
        do_load(16'h3333, 4'h0, 4'hF, 1'b0, 4'hF);
        run_frame();
        check("fb_d0", 16'(obs_seg[0][2]), 16'h30);

        // Mid-frame reset.
        phase = "midrst";
        run_until(4, 2);
        rst_n = 1'b0;
        step();
        check("mr_an",  16'(an),  16'hF);
        check("mr_seg", 16'(seg), 16'h7F);
        rst_n    = 1'b1;
        fd_count = 0;
        repeat (2 * D * R) step();
        check("mr_fd",   16'(fd_count),     16'd2);
        check("mr_dark", 16'(obs_an[1][3]), 16'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
